wb_arbiter: RTL

Writeback arbiter sitting directly upstream of the 32-entry register file. It merges three write sources into the register file's single write port, in fixed priority order:

- exception status writes to rstatus (r30),
- in-order pipeline results,
- out-of-order multiply/divide completions, buffered in a small FIFO.

It also keeps a busy scoreboard of registers awaiting a multdiv result, so decode can stall on RAW hazards.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 48 ++++
 rtl/wb_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared writeback types and constants for the register-file write arbiter.
package wb_pkg;

   localparam int unsigned REG_W       = 5;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned RSTATUS_REG = 30;

   // One register-file write request
   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   // Which source owns the write port this cycle
   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_EXC,
      SEL_PIPE,
      SEL_MD
   } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push when full and pop when empty are ignored.
module wb_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter type entry_t = logic [7:0]
) (
   input  logic   clock,
   input  logic   reset_n,
   input  logic   push,
   input  entry_t push_data,
   input  logic   pop,
   output entry_t head_c,
   output logic   full_c,
   output logic   empty_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned PW    = PTR_W + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   entry_t        mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign empty_c = (wr_ptr == rd_ptr);
   assign full_c  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign head_c  = mem[rd_ptr[PTR_W-1:0]];
   assign do_push = push && !full_c;
   assign do_pop  = pop && !empty_c;

   // Pointer update; both operations may happen in the same cycle
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage write; contents are don't-care while empty
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: exception > pipeline > buffered multdiv, plus busy scoreboard.
module wb_arbiter
   import wb_pkg::REG_W, wb_pkg::DATA_W, wb_pkg::wb_req_t, wb_pkg::wb_sel_e,
          wb_pkg::SEL_NONE, wb_pkg::SEL_EXC, wb_pkg::SEL_PIPE, wb_pkg::SEL_MD;
#(
   parameter int unsigned MD_DEPTH    = 2,
   parameter int unsigned RSTATUS_REG = wb_pkg::RSTATUS_REG
) (
   input  logic              clock,
   input  logic              ctrl_reset_n,
   input  logic              pipe_valid,
   input  logic [REG_W-1:0]  pipe_rd,
   input  logic [DATA_W-1:0] pipe_data,
   input  logic              exc_valid,
   input  logic [DATA_W-1:0] exc_code,
   input  logic              md_issue,
   input  logic [REG_W-1:0]  md_issue_rd,
   input  logic              md_valid,
   input  logic [REG_W-1:0]  md_rd,
   input  logic [DATA_W-1:0] md_data,
   output logic              md_ready,
   input  logic [REG_W-1:0]  ctrl_readRegA,
   input  logic [REG_W-1:0]  ctrl_readRegB,
   output logic              hazard_A,
   output logic              hazard_B,
   output logic              ctrl_writeEnable,
   output logic [REG_W-1:0]  ctrl_writeReg,
   output logic [DATA_W-1:0] data_writeReg
);

   localparam int unsigned NUM_REGS = 1 << REG_W;

   wb_req_t             push_req;
   wb_req_t             head;
   wb_req_t             sel_req;
   wb_sel_e             sel;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;

   assign push_req = '{valid: 1'b1, rd: md_rd, data: md_data};
   assign md_ready = !full;
   assign push     = md_valid && md_ready;
   assign pop      = (sel == SEL_MD);
   assign hazard_A = busy[ctrl_readRegA];
   assign hazard_B = busy[ctrl_readRegB];

   wb_fifo #(
      .DEPTH   (MD_DEPTH),
      .entry_t (wb_req_t)
   ) u_md_fifo (
      .clock     (clock),
      .reset_n   (ctrl_reset_n),
      .push      (push),
      .push_data (push_req),
      .pop       (pop),
      .head_c    (head),
      .full_c    (full),
      .empty_c   (empty)
   );

   // Fixed-priority source selection; a squashed pipeline write loses to an exception
   always_comb begin
      sel = SEL_NONE;
      if (exc_valid)       sel = SEL_EXC;
      else if (pipe_valid) sel = SEL_PIPE;
      else if (!empty)     sel = SEL_MD;
   end

   // Mux the winning request onto the write path
   always_comb begin
      sel_req = '0;
      case (sel)
         SEL_EXC:  sel_req = '{valid: 1'b1, rd: REG_W'(RSTATUS_REG), data: exc_code};
         SEL_PIPE: sel_req = '{valid: 1'b1, rd: pipe_rd, data: pipe_data};
         SEL_MD:   sel_req = head;
         default:  sel_req = '0;
      endcase
   end

   // Scoreboard next state: pop clears, issue sets (issue wins), r0 never busy
   always_comb begin
      busy_nxt = busy;
      if (pop)      busy_nxt[head.rd]     = 1'b0;
      if (md_issue) busy_nxt[md_issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Registered write port and scoreboard
   always_ff @(posedge clock) begin
      if (!ctrl_reset_n) begin
         busy             <= '0;
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= '0;
         data_writeReg    <= '0;
      end else begin
         busy             <= busy_nxt;
         ctrl_writeEnable <= sel_req.valid && (sel_req.rd != '0);
         ctrl_writeReg    <= sel_req.rd;
         data_writeReg    <= sel_req.data;
      end
   end

endmodule
